// File: rtl/sif_bfly_pkg.sv
// Shared types for the butterfly pair issuer: FSM states, sample layout, index-width helper.
// No latency or backpressure of its own; pure declarations.
package sif_bfly_pkg;

    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 16;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] re;
        logic [DEF_WIDTH-1:0] im;
    } cplx_t;

    // A buffer of depth 1 still needs a 1-bit index.
    function automatic int addr_w(input int stride);
        return (stride > 1) ? $clog2(stride) : 1;
    endfunction

endpackage

// File: rtl/sif_bfly_pair_buf.sv
// First-half sample store: synchronous write, combinational read at the pairing index.
// Zero read latency; no backpressure (writes only when the FSM accepts a sample).
module sif_bfly_pair_buf
    import sif_bfly_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STRIDE = 4,
    parameter int ADDR_W = addr_w(STRIDE)
) (
    input  logic                 clk,
    input  logic                 wr_en_i,
    input  logic [ADDR_W-1:0]    wr_addr_i,
    input  logic [2*WIDTH-1:0]   wr_dat_i,
    input  logic [ADDR_W-1:0]    rd_addr_i,
    output logic [2*WIDTH-1:0]   rd_dat_o
);

    logic [2*WIDTH-1:0] mem_q [STRIDE];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sif_bfly_pair_issuer.sv
// Issues butterfly pairs (x[i], x[i+STRIDE]) to an add/sub unit; 1 cycle from x[i+STRIDE] to A/B valid.
// A/B accepted jointly; X stalls in PAIR while a pair is held. SIF_BFLY_STALL_CNT_EN adds stall_cnt.
module sif_bfly_pair_issuer
    import sif_bfly_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X_vld,
    input  logic [WIDTH-1:0] X_real_dat,
    input  logic [WIDTH-1:0] X_img_dat,
    output logic             X_rdy,
    output logic             A_vld,
    output logic [WIDTH-1:0] A_real_dat,
    output logic [WIDTH-1:0] A_img_dat,
    input  logic             A_rdy,
    output logic             B_vld,
    output logic [WIDTH-1:0] B_real_dat,
    output logic [WIDTH-1:0] B_img_dat,
    input  logic             B_rdy,
    output logic             frame_done,
`ifdef SIF_BFLY_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             busy
);

    localparam int ADDR_W = addr_w(STRIDE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(STRIDE - 1);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } smp_t;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    smp_t              a_q, a_d;
    smp_t              b_q, b_d;
    smp_t              x_smp;
    logic [2*WIDTH-1:0] buf_rd_dat;
    logic              buf_we;
    logic              x_rdy_c;
    logic              fire;
    logic              load;

    assign x_smp = '{re: X_real_dat, im: X_img_dat};
    assign fire  = out_vld_q & A_rdy & B_rdy;

    sif_bfly_pair_buf #(
        .WIDTH  (WIDTH),
        .STRIDE (STRIDE),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_we),
        .wr_addr_i (idx_q),
        .wr_dat_i  (x_smp),
        .rd_addr_i (idx_q),
        .rd_dat_o  (buf_rd_dat)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        out_last_d = out_last_q;
        a_d        = a_q;
        b_d        = b_q;
        buf_we     = 1'b0;
        load       = 1'b0;
        x_rdy_c    = 1'b1;
        unique case (state_q)
            FILL: begin
                if (X_vld) begin
                    buf_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = PAIR;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            PAIR: begin
                // The output register may be refilled in the same cycle it drains.
                x_rdy_c = !out_vld_q | fire;
                if (X_vld && x_rdy_c) begin
                    load       = 1'b1;
                    a_d        = smp_t'(buf_rd_dat);
                    b_d        = x_smp;
                    out_last_d = (idx_q == LAST_IDX);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = FILL;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase

        if (load) begin
            out_vld_d = 1'b1;
        end else if (fire) begin
            out_vld_d = 1'b0;
        end else begin
            out_vld_d = out_vld_q;
        end
        frame_done_d = fire & out_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            idx_q        <= '0;
            out_vld_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            out_vld_q    <= out_vld_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

`ifdef SIF_BFLY_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_vld_q && !(A_rdy && B_rdy) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign X_rdy      = x_rdy_c;
    assign A_vld      = out_vld_q;
    assign B_vld      = out_vld_q;
    assign A_real_dat = a_q.re;
    assign A_img_dat  = a_q.im;
    assign B_real_dat = b_q.re;
    assign B_img_dat  = b_q.im;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == PAIR) | out_vld_q;

endmodule

// File: tb/tb_sif_bfly_pair_issuer.sv
// Bench for sif_bfly_pair_issuer: STRIDE=4 instance checked through a pair scoreboard,
// plus a STRIDE=1 instance driven by a short hand-written sequence.
module tb_sif_bfly_pair_issuer;

    localparam int W = 16;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         X_vld = 1'b0;
    logic [W-1:0] X_re = '0, X_im = '0;
    logic         X_rdy;
    logic         A_vld, B_vld, frame_done, busy;
    logic [W-1:0] A_re, A_im, B_re, B_im;
    logic         a_man = 1'b1, b_man = 1'b1, a_rnd = 1'b1, b_rnd = 1'b1, rand_en = 1'b0;
    logic         A_rdy, B_rdy;
    assign A_rdy = rand_en ? a_rnd : a_man;
    assign B_rdy = rand_en ? b_rnd : b_man;
`ifdef SIF_BFLY_STALL_CNT_EN
    logic [31:0]  stall_cnt, stall_cnt1;
`endif

    sif_bfly_pair_issuer #(.WIDTH(W), .STRIDE(S)) dut (
        .clk(clk), .rst(rst),
        .X_vld(X_vld), .X_real_dat(X_re), .X_img_dat(X_im), .X_rdy(X_rdy),
        .A_vld(A_vld), .A_real_dat(A_re), .A_img_dat(A_im), .A_rdy(A_rdy),
        .B_vld(B_vld), .B_real_dat(B_re), .B_img_dat(B_im), .B_rdy(B_rdy),
        .frame_done(frame_done),
`ifdef SIF_BFLY_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .busy(busy)
    );

    logic         x1_vld = 1'b0;
    logic [W-1:0] x1_re = '0, x1_im = '0;
    logic         x1_rdy, a1_vld, b1_vld, fd1, busy1;
    logic [W-1:0] a1_re, a1_im, b1_re, b1_im;

    sif_bfly_pair_issuer #(.WIDTH(W), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst),
        .X_vld(x1_vld), .X_real_dat(x1_re), .X_img_dat(x1_im), .X_rdy(x1_rdy),
        .A_vld(a1_vld), .A_real_dat(a1_re), .A_img_dat(a1_im), .A_rdy(1'b1),
        .B_vld(b1_vld), .B_real_dat(b1_re), .B_img_dat(b1_im), .B_rdy(1'b1),
        .frame_done(fd1),
`ifdef SIF_BFLY_STALL_CNT_EN
        .stall_cnt(stall_cnt1),
`endif
        .busy(busy1)
    );

    typedef struct {
        logic [W-1:0] a_re, a_im, b_re, b_im;
        logic         last;
    } pair_t;

    typedef struct {
        logic [W-1:0] x;
        logic         has_pair;
        logic [W-1:0] ea, eb;
        logic         last;
    } vec_t;

    pair_t        sb[$];
    int           total = 0, bad = 0;
    int           pop_cnt = 0, fd_cnt = 0, xrdy_drops = 0;
    logic         fd_exp = 1'b0, hold_v = 1'b0;
    logic [W-1:0] h_are, h_aim, h_bre, h_bim;
    logic [W-1:0] fbuf [S];
    int           mpos = 0;
    logic         use_tbl = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model of the pairing: remember the first half, pair with the second.
    task automatic model_accept(input logic [W-1:0] re, input logic [W-1:0] im);
        pair_t p;
        if (mpos < S) begin
            fbuf[mpos] = re;
        end else if (!use_tbl) begin
            p.a_re = fbuf[mpos-S];
            p.a_im = fbuf[mpos-S] + 16'h0100;
            p.b_re = re;
            p.b_im = im;
            p.last = (mpos == 2*S-1);
            sb.push_back(p);
        end
        mpos = (mpos == 2*S-1) ? 0 : mpos + 1;
    endtask

    task automatic send(input logic [W-1:0] re);
        int n = 0;
        X_vld = 1'b1; X_re = re; X_im = re + 16'h0100;
        @(negedge clk);
        while (!X_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!X_rdy) begin
            chk("send_timeout", 32'd0, 32'd1);
            X_vld = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model_accept(re, re + 16'h0100);
    endtask

    task automatic idle(input int n);
        X_vld = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        X_vld = 1'b0;
        rst = 1'b1;
        sb.delete();
        mpos = 0;
        fd_exp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
        idle(3);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
            fd_exp = 1'b0;
        end else begin
            chk("frame_done", frame_done, fd_exp);
            if (frame_done) fd_cnt++;
            if (X_vld && !X_rdy) xrdy_drops++;
            if (A_vld !== B_vld) chk("a_vld_eq_b_vld", B_vld, A_vld);
            if (hold_v) begin
                chk("hold_vld", A_vld, 1);
                chk("hold_data", {A_re, A_im, B_re, B_im}, {h_are, h_aim, h_bre, h_bim});
            end
            fd_exp = 1'b0;
            if (A_vld && A_rdy && B_rdy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pair", {A_re, B_re}, 32'hFFFF_FFFF);
                end else begin
                    pair_t p;
                    p = sb.pop_front();
                    pop_cnt++;
                    chk("pair_a", {A_re, A_im}, {p.a_re, p.a_im});
                    chk("pair_b", {B_re, B_im}, {p.b_re, p.b_im});
                    fd_exp = p.last;
                end
            end
            hold_v = A_vld && !(A_rdy && B_rdy);
            h_are = A_re; h_aim = A_im; h_bre = B_re; h_bim = B_im;
        end
    end

    initial begin
        int fd0, pc0;
        vec_t tbl [8];
        logic [3:0] v1 [7];
        logic [W-1:0] a1 [7], b1 [7];
        logic [W-1:0] s1 [4];

        for (int i = 0; i < 8; i++) begin
            tbl[i].x        = W'(i + 1);
            tbl[i].has_pair = (i >= 4);
            tbl[i].ea       = W'(i - 3);
            tbl[i].eb       = W'(i + 1);
            tbl[i].last     = (i == 7);
        end

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_a_vld", A_vld, 0);
        chk("rst_x_rdy", X_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_a_data", {A_re, A_im}, 0);
        chk("rst_b_data", {B_re, B_im}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single frame from the vector table, readys held high.
        fd0 = fd_cnt; pc0 = pop_cnt;
        use_tbl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].x);
            if (tbl[i].has_pair) begin
                pair_t p;
                p.a_re = tbl[i].ea; p.a_im = tbl[i].ea + 16'h0100;
                p.b_re = tbl[i].eb; p.b_im = tbl[i].eb + 16'h0100;
                p.last = tbl[i].last;
                sb.push_back(p);
            end
        end
        use_tbl = 1'b0;
        idle(1);
        drain();
        chk("t1_pairs", pop_cnt - pc0, 4);
        chk("t1_frame_done_cnt", fd_cnt - fd0, 1);

        // A-side stall while pair (2,6) is held.
        do_reset();
        for (int i = 1; i <= 6; i++) send(W'(i));
        a_man = 1'b0;
        X_vld = 1'b1; X_re = 16'h0007; X_im = 16'h0107;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_a_vld", A_vld, 1);
            chk("stall_a", A_re, 16'h0002);
            chk("stall_b", B_re, 16'h0006);
            chk("stall_x_rdy", X_rdy, 0);
            @(posedge clk);
        end
        #1;
`ifdef SIF_BFLY_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 5);
`endif
        a_man = 1'b1;
        send(16'h0007);
        send(16'h0008);
        idle(1);
        drain();

        // Back-to-back frames, no input stalls expected.
        fd0 = fd_cnt; pc0 = pop_cnt; xrdy_drops = 0;
        for (int i = 1; i <= 16; i++) send(W'(i));
        idle(1);
        drain();
        chk("b2b_x_rdy_drops", xrdy_drops, 0);
        chk("b2b_pairs", pop_cnt - pc0, 8);
        chk("b2b_frame_done_cnt", fd_cnt - fd0, 2);

        // Reset mid-frame with a pair pending.
        for (int i = 1; i <= 6; i++) send(W'(16'h0030 + i));
        a_man = 1'b0;
        X_vld = 1'b0;
        do_reset();
        a_man = 1'b1;
        @(negedge clk);
        chk("mrst_a_vld", A_vld, 0);
        chk("mrst_x_rdy", X_rdy, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_a_data", A_re, 0);
        @(posedge clk); #1;
        pc0 = pop_cnt;
        for (int i = 1; i <= 8; i++) send(W'(16'h0020 + i));
        idle(1);
        drain();
        chk("mrst_pairs", pop_cnt - pc0, 4);

        // STRIDE=1 instance: A,B,C,D -> (A,B), (C,D).
        s1[0] = 16'h000A; s1[1] = 16'h000B; s1[2] = 16'h000C; s1[3] = 16'h000D;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            x1_vld = (k < 4);
            x1_re  = (k < 4) ? s1[k] : '0;
            x1_im  = x1_re + 16'h0100;
            @(negedge clk);
            v1[k] = {a1_vld, b1_vld, fd1, x1_rdy};
            a1[k] = a1_re;
            b1[k] = b1_re;
        end
        x1_vld = 1'b0;
        chk("s1_pair0_vld", v1[2][3:2], 2'b11);
        chk("s1_pair0", {a1[2], b1[2]}, {16'h000A, 16'h000B});
        chk("s1_pair1_vld", v1[4][3:2], 2'b11);
        chk("s1_pair1", {a1[4], b1[4]}, {16'h000C, 16'h000D});
        chk("s1_fd_cnt", 32'(v1[0][1]) + 32'(v1[1][1]) + 32'(v1[2][1]) + 32'(v1[3][1])
                         + 32'(v1[4][1]) + 32'(v1[5][1]) + 32'(v1[6][1]), 2);
        chk("s1_fd_timing", {v1[3][1], v1[5][1]}, 2'b11);
        chk("s1_x_rdy", {v1[0][0], v1[1][0], v1[2][0], v1[3][0]}, 4'hF);

        // Random joint-ready toggling over 100 frames.
        idle(2);
        fd0 = fd_cnt; pc0 = pop_cnt;
        rand_en = 1'b1;
        for (int f = 0; f < 100; f++) begin
            for (int i = 0; i < 2*S; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(W'($urandom_range(0, 16'hFEFF)));
            end
        end
        X_vld = 1'b0;
        rand_en = 1'b0;
        drain();
        chk("rand_pairs", pop_cnt - pc0, 400);
        chk("rand_frame_done_cnt", fd_cnt - fd0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            a_rnd = ($urandom_range(0, 2) != 0);
            b_rnd = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sif_bfly_pair_issuer.md
Name: sif_bfly_pair_issuer

Overview:
- Transmit side of the complex adder operand interface. Drives the A and B operand streams of the half-fp complex add/sub unit.
- Takes one input stream of complex samples framed as 2*STRIDE consecutive samples.
- Buffers the first STRIDE samples, then issues butterfly pairs (x[i], x[i+STRIDE]) as A = x[i], B = x[i+STRIDE], with A_vld and B_vld presented together.
- Sits between the stage sample buffer and each add/sub instance of a butterfly stage.

Parameters:
- WIDTH, 16, bit width of each real/imag component (half-fp bit pattern, passed through untouched).
- STRIDE, 4, butterfly distance. Power of two, 1 to 1024.
- ADDR_W, $clog2(STRIDE) with a minimum of 1, buffer index width. Derived; never overridden.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- X_vld  in  1  input sample valid
- X_real_dat  in  WIDTH  input real part
- X_img_dat  in  WIDTH  input imaginary part
- X_rdy  out  1  input ready
- A_vld  out  1  operand A valid (always equals B_vld)
- A_real_dat  out  WIDTH  operand A real part
- A_img_dat  out  WIDTH  operand A imaginary part
- A_rdy  in  1  adder A ready
- B_vld  out  1  operand B valid
- B_real_dat  out  WIDTH  operand B real part
- B_img_dat  out  WIDTH  operand B imaginary part
- B_rdy  in  1  adder B ready
- frame_done  out  1  one-cycle pulse on transfer of a frame's last pair
- busy  out  1  high when in PAIR state or when out_vld=1

Behaviour:
- Reset (synchronous, active-high):
  - state=FILL, idx=0, out_vld=0, frame_done=0.
  - A/B data registers cleared to 0. The buffer RAM is not cleared.
  - A reset in mid-frame discards the partial frame and any pending pair.
- Definitions:
  - xfer_in = X_vld & X_rdy
  - fire = out_vld & A_rdy & B_rdy. A and B are accepted jointly; a single side's ready alone never completes a transfer.
- FILL state:
  - X_rdy=1.
  - On xfer_in, write buf[idx] = {X_real_dat, X_img_dat} and increment idx.
  - When the write lands at idx=STRIDE-1: idx goes to 0, state goes to PAIR.
- PAIR state:
  - X_rdy = !out_vld | fire.
  - On xfer_in, load the output register: A = buf[idx], B = X, out_last = (idx==STRIDE-1); set out_vld=1; increment idx.
  - When the load happens at idx=STRIDE-1: idx goes to 0, state goes to FILL.
- Output register:
  - A_vld = B_vld = out_vld.
  - On fire without a new load, out_vld goes to 0.
  - On fire together with a load in the same cycle, out_vld stays 1 with the new data, so full throughput is kept.
  - Data and valid stay stable while out_vld & !fire. Valid is never withdrawn before fire.
- Overlap: FILL of the next frame may proceed while the last pair of the previous frame is still pending. This is safe because the pair was already copied to the output register.
- frame_done: registered; high in the cycle after a fire with out_last=1.
- Latency: one cycle from xfer_in of x[i+STRIDE] to A_vld/B_vld high.
- STRIDE=1: FILL holds one sample, PAIR issues one pair. Frames alternate FILL/PAIR every accepted sample.
- Data is pure pass-through; there is no arithmetic on the samples.

Optional Feature:
- Macro: SIF_BFLY_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits.
  - Increments every cycle with out_vld & !(A_rdy & B_rdy); saturates at 0xFFFFFFFF.
  - Cleared by rst.
- Undefined: the port and the counter logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package sif_bfly_pkg:
  - state enum {FILL, PAIR}
  - complex sample struct {real, img} of WIDTH
  - function for ADDR_W derivation
- One natural sub-module: sif_bfly_pair_buf, a simple dual-port STRIDE x 2*WIDTH buffer with write in FILL and combinational read at idx in PAIR. Inferred as distributed RAM.

Test Plan:
- STRIDE=4, A_rdy=B_rdy=1, stream x=0x0001..0x0008 (real), imag = real+0x100 -> pairs (1,5), (2,6), (3,7), (4,8); frame_done pulses once, one cycle after pair (4,8).
- Hold A_rdy=0, B_rdy=1 for 5 cycles while pair (2,6) is pending -> A/B data stable, X_rdy=0, no transfer; with SIF_BFLY_STALL_CNT_EN, stall_cnt=5.
- Back-to-back frames 0x01..0x10 with readys always 1 -> X_rdy never drops; 8 pairs issued; two frame_done pulses.
- Assert rst after 6 samples of a frame -> out_vld=0, X_rdy=1; the next 8 samples 0x21..0x28 yield pairs (21,25) ... (24,28).
- STRIDE=1, stream 0xA, 0xB, 0xC, 0xD -> pairs (A,B), (C,D); frame_done pulses twice.
- Random A_rdy/B_rdy toggling over 100 frames -> scoreboard matches every pair in order, no drops or duplicates.
